dff_pipe_bank: RTL and testbench

DFF_PIPE_BANK -- requirements
Module: dff_pipe_bank

---
 rtl/dff_pipe_bank.sv | 146 ++++++++++++++
 tb/tb_dff_pipe_bank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe_bank.sv
// dff_pipe_bank: a bank of DEPTH registered stages with a valid bit per stage.
// Words advance one stage per enabled cycle. When the consumer stalls, the
// words behind a hole still slide forward into it. The bank also provides a
// synchronous clear, a sticky input-loss flag, an occupancy count and a
// combinational tap read.
module dff_pipe_bank #(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 4,
   parameter bit               EN_INV  = 1'b0,
   parameter logic [WIDTH-1:0] SR_VAL  = '0,
   parameter logic [WIDTH-1:0] CLR_VAL = '0,
   localparam int              SEL_W   = $clog2(DEPTH),
   localparam int              CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             sr,
   input  logic             en,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] d,
   output logic             in_ready,
   output logic [WIDTH-1:0] q,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic [SEL_W-1:0] tap_sel,
   output logic [WIDTH-1:0] tap_q,
   output logic [CNT_W-1:0] count,
   output logic             drop
);

   logic             en_eff;
   logic             unstalled;
   logic [DEPTH-1:0] valid_vec;
   logic [DEPTH-1:0] valid_next;
   logic [DEPTH-1:0] hole;
   logic [DEPTH-1:0] load;
   logic [WIDTH-1:0] stage_data [DEPTH];
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             drop_reg;

   assign en_eff    = en ^ EN_INV;
   // The last stage is free whenever it is empty or being consumed.
   assign unstalled = en_eff & (~valid_vec[DEPTH-1] | out_ready);

   // hole[i]: some stage at or beyond i is empty, so stage i can slide forward
   // even while the output is stalled.
   always_comb begin
      hole = '0;
      hole[DEPTH-1] = ~valid_vec[DEPTH-1];
      for (int i = DEPTH - 2; i >= 0; i--) begin
         hole[i] = ~valid_vec[i] | hole[i+1];
      end
   end

   // A stage loads from its predecessor (stage 0 loads from the input) when it
   // either is part of a free-running shift or has a hole at or ahead of it.
   always_comb begin
      load = '0;
      for (int i = 0; i < DEPTH; i++) begin
         load[i] = unstalled | (en_eff & hole[i]);
      end
   end

   assign in_ready = load[0];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic             valid_reg;
         logic [WIDTH-1:0] data_reg;
         logic             src_valid;
         logic [WIDTH-1:0] src_data;

         if (gi == 0) begin : g_src_in
            assign src_valid = in_valid;
            assign src_data  = d;
         end else begin : g_src_prev
            assign src_valid = valid_vec[gi-1];
            assign src_data  = stage_data[gi-1];
         end

         assign valid_next[gi] = clr ? 1'b0 : (load[gi] ? src_valid : valid_reg);

         // Stage register: data is only overwritten when a valid word arrives.
         always_ff @(posedge clk or negedge sr) begin
            if (!sr) begin
               valid_reg <= 1'b0;
               data_reg  <= SR_VAL;
            end else if (clr) begin
               valid_reg <= 1'b0;
               data_reg  <= CLR_VAL;
            end else if (load[gi]) begin
               valid_reg <= src_valid;
               if (src_valid) begin
                  data_reg <= src_data;
               end
            end
         end

         assign valid_vec[gi]  = valid_reg;
         assign stage_data[gi] = data_reg;
      end
   endgenerate

   // Occupancy after the edge is the population count of the next valid bits.
   always_comb begin
      count_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_next = count_next + CNT_W'(valid_next[i]);
      end
   end

   // Registered occupancy count.
   always_ff @(posedge clk or negedge sr) begin
      if (!sr) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   // Sticky loss flag: set by any offered word that is not taken.
   always_ff @(posedge clk or negedge sr) begin
      if (!sr) begin
         drop_reg <= 1'b0;
      end else if (clr) begin
         drop_reg <= 1'b0;
      end else if (in_valid && !in_ready) begin
         drop_reg <= 1'b1;
      end
   end

   // Tap read. Out-of-range selects fall back to the last stage.
   always_comb begin
      tap_q = stage_data[DEPTH-1];
      if (int'(tap_sel) < DEPTH) begin
         tap_q = stage_data[tap_sel];
      end
   end

   assign q         = stage_data[DEPTH-1];
   assign out_valid = valid_vec[DEPTH-1];
   assign count     = count_reg;
   assign drop      = drop_reg;

endmodule

// File: tb/tb_dff_pipe_bank.sv
// Testbench for dff_pipe_bank. Two instances share all stimulus: one has an
// active-high enable and the other an inverted enable driven with ~en. Both
// instances must therefore match the same reference model. The model keeps
// stage contents in arrays and accepted words in a queue.
module tb_dff_pipe_bank;

   localparam int         W    = 8;
   localparam int         D    = 4;
   localparam logic [7:0] SRV  = 8'hA5;
   localparam logic [7:0] CLRV = 8'h3C;

   logic       clk = 1'b0;
   logic       sr = 1'b1;
   logic       en = 1'b0;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] d = '0;
   logic [1:0] tap_sel = '0;
   logic       en_n;

   logic       in_ready_a, out_valid_a, drop_a;
   logic       in_ready_b, out_valid_b, drop_b;
   logic [7:0] q_a, tap_q_a, q_b, tap_q_b;
   logic [2:0] count_a, count_b;

   int tests = 0;
   int errors = 0;

   // reference model state
   logic [7:0] md [D];
   bit         mv [D];
   bit         mdrop;
   logic [7:0] sb [$];

   always #10 clk = ~clk;
   assign en_n = ~en;

   dff_pipe_bank #(.WIDTH(W), .DEPTH(D), .EN_INV(1'b0), .SR_VAL(SRV), .CLR_VAL(CLRV)) dut_a (
      .clk(clk), .sr(sr), .en(en), .clr(clr), .in_valid(in_valid), .d(d),
      .in_ready(in_ready_a), .q(q_a), .out_valid(out_valid_a), .out_ready(out_ready),
      .tap_sel(tap_sel), .tap_q(tap_q_a), .count(count_a), .drop(drop_a));

   dff_pipe_bank #(.WIDTH(W), .DEPTH(D), .EN_INV(1'b1), .SR_VAL(SRV), .CLR_VAL(CLRV)) dut_b (
      .clk(clk), .sr(sr), .en(en_n), .clr(clr), .in_valid(in_valid), .d(d),
      .in_ready(in_ready_b), .q(q_b), .out_valid(out_valid_b), .out_ready(out_ready),
      .tap_sel(tap_sel), .tap_q(tap_q_b), .count(count_b), .drop(drop_b));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < D; i++) n += int'(mv[i]);
      return n;
   endfunction

   // Highest stage index that shifts this cycle. It is the last stage when the
   // output is free. Otherwise it is the topmost empty slot, and -1 means full
   // and stalled.
   function automatic int m_top();
      if (!(mv[D-1] && !out_ready)) return D - 1;
      for (int j = D - 1; j >= 0; j--) if (!mv[j]) return j;
      return -1;
   endfunction

   function automatic bit m_ready();
      return en && (m_top() >= 0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < D; i++) begin
         md[i] = SRV;
         mv[i] = 1'b0;
      end
      mdrop = 1'b0;
      sb.delete();
   endtask

   task automatic check_state();
      check("a.q", q_a, md[D-1]);
      check("b.q", q_b, md[D-1]);
      check("a.out_valid", out_valid_a, mv[D-1]);
      check("b.out_valid", out_valid_b, mv[D-1]);
      check("a.count", count_a, m_count());
      check("b.count", count_b, m_count());
      check("a.drop", drop_a, mdrop);
      check("b.drop", drop_b, mdrop);
      check("a.in_ready", in_ready_a, m_ready());
      check("b.in_ready", in_ready_b, m_ready());
      for (int t = 0; t < D; t++) begin
         tap_sel = 2'(t);
         #1;
         check($sformatf("a.tap%0d", t), tap_q_a, md[t]);
         check($sformatf("b.tap%0d", t), tap_q_b, md[t]);
      end
   endtask

   // Advance the model across the coming rising edge using the current inputs.
   task automatic model_step();
      bit rdy;
      int top;
      rdy = m_ready();
      top = m_top();
      if (clr) begin
         for (int i = 0; i < D; i++) begin
            md[i] = CLRV;
            mv[i] = 1'b0;
         end
         mdrop = 1'b0;
         sb.delete();
      end else begin
         if (in_valid && !rdy) mdrop = 1'b1;
         if (en && mv[D-1] && out_ready) begin
            if (sb.size() > 0) check("order", q_a, sb.pop_front());
            else check("order_empty", 64'(sb.size()), 64'd1);
         end
         if (rdy) begin
            if (in_valid) sb.push_back(d);
            for (int k = top; k >= 1; k--) begin
               if (mv[k-1]) md[k] = md[k-1];
               mv[k] = mv[k-1];
            end
            mv[0] = in_valid;
            if (in_valid) md[0] = d;
         end
      end
   endtask

   task automatic cycle(input bit iv, input logic [7:0] dd, input bit orr, input bit e, input bit c);
      @(negedge clk);
      in_valid  = iv;
      d         = dd;
      out_ready = orr;
      en        = e;
      clr       = c;
      #1;
      check_state();
      model_step();
   endtask

   // Assert reset between edges, check the asynchronous effect, then release.
   task automatic do_reset();
      #2;
      sr = 1'b0;
      #1;
      check("rst.q_a", q_a, SRV);
      check("rst.q_b", q_b, SRV);
      check("rst.out_valid_a", out_valid_a, 1'b0);
      check("rst.count_a", count_a, 3'd0);
      check("rst.drop_b", drop_b, 1'b0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      en       = 1'b0;
      clr      = 1'b0;
      sr       = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();

      // three-word stream, consumer always ready
      cycle(1, 8'h01, 1, 1, 0);
      cycle(1, 8'h02, 1, 1, 0);
      cycle(1, 8'h03, 1, 1, 0);
      for (int i = 0; i < 6; i++) cycle(0, 8'h00, 1, 1, 0);

      // stalled consumer: four fit, the fifth is lost, then drain
      for (int i = 0; i < 5; i++) cycle(1, 8'h10 + 8'(i), 0, 1, 0);
      cycle(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 6; i++) cycle(0, 8'h00, 1, 1, 0);

      // enable inactive: nothing moves, nothing is accepted
      cycle(1, 8'h55, 1, 0, 0);
      cycle(1, 8'h56, 1, 0, 0);
      cycle(1, 8'h57, 1, 1, 0);

      // three words held with drop set, then clear with a word offered
      cycle(1, 8'h21, 0, 1, 1);
      cycle(1, 8'h22, 0, 1, 0);
      cycle(1, 8'h23, 0, 1, 0);
      cycle(1, 8'h24, 0, 1, 0);
      cycle(1, 8'h25, 0, 0, 0);
      cycle(1, 8'h26, 0, 1, 1);
      cycle(0, 8'h00, 0, 1, 0);

      // stages 3 and 1 valid, then a stall collapses the bubble
      cycle(1, 8'h31, 1, 1, 0);
      cycle(0, 8'h00, 1, 1, 0);
      cycle(1, 8'h32, 1, 1, 0);
      cycle(0, 8'h00, 1, 1, 0);
      cycle(0, 8'h00, 0, 1, 0);
      cycle(0, 8'h00, 0, 1, 0);
      cycle(0, 8'h00, 1, 1, 0);

      // mid-stream reset discards in-flight words
      cycle(1, 8'h41, 0, 1, 0);
      cycle(1, 8'h42, 0, 1, 0);
      do_reset();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 99) < 60, 8'($urandom),
                  $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 90,
                  $urandom_range(0, 99) < 3);
         end
      end
      cycle(0, 8'h00, 1, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
